// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-address type used by the hazard logic.
package cpu_pkg;
  localparam int REG_ADDR_W       = 5;
  localparam int NUM_ARCH_REGS    = 32;
  localparam int REG_ZERO         = 0;
  localparam int DEFAULT_LOAD_LAT = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/lus_counter.sv
// One scoreboard entry: a down-counter that reloads on allocation and holds under freeze.
module lus_counter #(
  parameter int CNT_W    = 1,
  parameter int LOAD_VAL = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hold_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (!hold_i) begin
      if (load_i) begin
        cnt_o <= CNT_W'(LOAD_VAL);
      end else if (cnt_o != '0) begin
        cnt_o <= cnt_o - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: per-register countdown of in-flight loads driving stall/bubble.
// Optional macro LOAD_USE_PERF_EN adds a saturating bubble counter (stall_cnt_o, perf_clr_i).
module load_use_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT,
  parameter int CNT_W    = $clog2(LOAD_LAT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_mem_read_i,
  input  logic [ADDR_W-1:0] id_rd_addr_i,
  input  logic              freeze_i,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o
`ifdef LOAD_USE_PERF_EN
  ,
  input  logic              perf_clr_i,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int SLOTS = 2 ** ADDR_W;

  logic [SLOTS-1:0] busy;
  logic             issue;
  logic             alloc;

  assign stall_o = id_valid_i & ((id_uses_rs_i & busy[id_rs_addr_i]) |
                                 (id_uses_rt_i & busy[id_rt_addr_i]));
  assign issue   = id_valid_i & ~stall_o & ~freeze_i;
  assign alloc   = issue & id_mem_read_i;

  assign pc_write_o    = ~stall_o & ~freeze_i;
  assign ifid_write_o  = ~stall_o & ~freeze_i;
  assign idex_bubble_o = stall_o & ~freeze_i;

  // Register zero and addresses beyond NUM_REGS get no counter, so they never look busy.
  for (genvar r = 0; r < SLOTS; r++) begin : g_slot
    if (r != REG_ZERO && r < NUM_REGS) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      lus_counter #(
        .CNT_W   (CNT_W),
        .LOAD_VAL(LOAD_LAT)
      ) u_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .hold_i (freeze_i),
        .load_i (alloc && (id_rd_addr_i == ADDR_W'(r))),
        .cnt_o  (cnt)
      );
      assign busy[r] = (cnt != '0);
    end else begin : g_none
      assign busy[r] = 1'b0;
    end
  end

`ifdef LOAD_USE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
    end else if (idex_bubble_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard: three instances (latency 1/2/3) share one ID-stage stimulus.
module tb_load_use_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] rd;
    logic       frz;
  } stim_t;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       id_valid_i, id_uses_rs_i, id_uses_rt_i, id_mem_read_i, freeze_i;
  logic [4:0] id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
  logic       stall1, pcw1, ifid1, bub1;
  logic       stall2, pcw2, ifid2, bub2;
  logic       stall3, pcw3, ifid3, bub3;
`ifdef LOAD_USE_PERF_EN
  logic        perf_clr_i;
  logic [31:0] scnt1, scnt2, scnt3;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  load_use_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LOAD_LAT(1)) dut1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_mem_read_i(id_mem_read_i), .id_rd_addr_i(id_rd_addr_i), .freeze_i(freeze_i),
    .stall_o(stall1), .pc_write_o(pcw1), .ifid_write_o(ifid1), .idex_bubble_o(bub1)
`ifdef LOAD_USE_PERF_EN
    , .perf_clr_i(perf_clr_i), .stall_cnt_o(scnt1)
`endif
  );

  load_use_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LOAD_LAT(2)) dut2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_mem_read_i(id_mem_read_i), .id_rd_addr_i(id_rd_addr_i), .freeze_i(freeze_i),
    .stall_o(stall2), .pc_write_o(pcw2), .ifid_write_o(ifid2), .idex_bubble_o(bub2)
`ifdef LOAD_USE_PERF_EN
    , .perf_clr_i(perf_clr_i), .stall_cnt_o(scnt2)
`endif
  );

  load_use_scoreboard #(.NUM_REGS(24), .ADDR_W(5), .LOAD_LAT(3)) dut3 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_mem_read_i(id_mem_read_i), .id_rd_addr_i(id_rd_addr_i), .freeze_i(freeze_i),
    .stall_o(stall3), .pc_write_o(pcw3), .ifid_write_o(ifid3), .idex_bubble_o(bub3)
`ifdef LOAD_USE_PERF_EN
    , .perf_clr_i(perf_clr_i), .stall_cnt_o(scnt3)
`endif
  );

  // Observed control vector {stall, pc_write, ifid_write, bubble} of one instance.
  function automatic logic [3:0] obs(input int d);
    case (d)
      1:       return {stall1, pcw1, ifid1, bub1};
      2:       return {stall2, pcw2, ifid2, bub2};
      default: return {stall3, pcw3, ifid3, bub3};
    endcase
  endfunction

  function automatic stim_t s_idle();
    return '0;
  endfunction

  function automatic stim_t s_ld(input logic [4:0] rd);
    stim_t s = '0;
    s.v = 1'b1; s.mr = 1'b1; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t s_dep(input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt);
    stim_t s = '0;
    s.v = 1'b1; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_valid_i    = s.v;
    id_rs_addr_i  = s.rs;
    id_rt_addr_i  = s.rt;
    id_uses_rs_i  = s.urs;
    id_uses_rt_i  = s.urt;
    id_mem_read_i = s.mr;
    id_rd_addr_i  = s.rd;
    freeze_i      = s.frz;
  endtask

  task automatic drain();
    apply(s_idle());
    repeat (8) @(posedge clk_i);
    #1;
  endtask

  localparam logic [3:0] RUN   = 4'b0110;
  localparam logic [3:0] STALL = 4'b1001;
  localparam logic [3:0] FRZ_S = 4'b1000;

  task automatic test_reset();
    logic [3:0] got;
    rst_n_i = 1'b0;
    apply(s_dep(5'd5, 1'b1, 5'd9, 1'b1));
    #3;
    for (int d = 1; d <= 3; d++) begin
      got = obs(d);
      n_cmp++;
      if (got !== RUN) begin
        n_err++;
        $display("FAIL reset dut%0d got=%b want=%b", d, got, RUN);
      end
    end
`ifdef LOAD_USE_PERF_EN
    perf_clr_i = 1'b0;
    n_cmp++;
    if (scnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_perf got=%0d want=0", scnt1);
    end
`endif
    #9 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_classic();
    stim_t sq[$];
    logic [3:0] got, want;
    sq = '{s_ld(5'd5), s_dep(5'd5, 1'b1, 5'd0, 1'b0), s_dep(5'd5, 1'b1, 5'd0, 1'b0)};
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back((i == 1) ? STALL : RUN);
      @(negedge clk_i);
      got = obs(1); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL classic cyc%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk_i); #1;
    end
    drain();
  endtask

  task automatic test_lat3();
    stim_t sq[$];
    logic [3:0] eq[$];
    logic [3:0] got, want;
    sq = '{s_ld(5'd7), s_dep(5'd0, 1'b0, 5'd7, 1'b1), s_dep(5'd0, 1'b0, 5'd7, 1'b1),
           s_dep(5'd0, 1'b0, 5'd7, 1'b1), s_dep(5'd0, 1'b0, 5'd7, 1'b1),
           s_ld(5'd7), s_dep(5'd7, 1'b0, 5'd7, 1'b0), s_dep(5'd7, 1'b0, 5'd7, 1'b0)};
    eq = '{RUN, STALL, STALL, STALL, RUN, RUN, RUN, RUN};
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk_i);
      got = obs(3); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lat3 cyc%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk_i); #1;
    end
    drain();
  endtask

  task automatic test_reg_zero();
    stim_t sq[$];
    logic [3:0] got, want;
    // r0 never pends; r25 lies outside dut3's 24-register file.
    sq = '{s_ld(5'd0), s_dep(5'd0, 1'b1, 5'd0, 1'b1), s_dep(5'd0, 1'b1, 5'd0, 1'b1),
           s_ld(5'd25), s_dep(5'd25, 1'b1, 5'd25, 1'b1), s_dep(5'd25, 1'b1, 5'd25, 1'b1)};
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(RUN);
      @(negedge clk_i);
      for (int d = 1; d <= 3; d++) begin
        got = obs(d);
        want = (d == 3) ? exp_q.pop_front() : ((i < 3) ? RUN : obs(d));
        if (d == 3 || i < 3) begin
          n_cmp++;
          if (got !== want) begin
            n_err++;
            $display("FAIL reg_zero dut%0d cyc%0d got=%b want=%b", d, i, got, want);
          end
        end
      end
      @(posedge clk_i); #1;
    end
    drain();
  endtask

  task automatic test_freeze();
    stim_t sq[$];
    stim_t f;
    logic [3:0] eq[$];
    logic [3:0] got, want;
    int bubbles = 0;
    f = s_dep(5'd3, 1'b1, 5'd0, 1'b0);
    f.frz = 1'b1;
    sq = '{s_ld(5'd3), s_dep(5'd3, 1'b1, 5'd0, 1'b0), f, f, f, f,
           s_dep(5'd3, 1'b1, 5'd0, 1'b0), s_dep(5'd3, 1'b1, 5'd0, 1'b0)};
    eq = '{RUN, STALL, FRZ_S, FRZ_S, FRZ_S, FRZ_S, STALL, RUN};
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk_i);
      got = obs(2); want = exp_q.pop_front();
      if (got[0] === 1'b1) bubbles++;
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL freeze cyc%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if (bubbles != 2) begin
      n_err++;
      $display("FAIL freeze_bubbles got=%0d want=2", bubbles);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    stim_t sl;
    logic [3:0] eq[$];
    logic [3:0] got, want;
    sl = s_ld(5'd8);
    sl.rs = 5'd4; sl.urs = 1'b1;
    sq = '{s_ld(5'd4), s_ld(5'd4), s_dep(5'd4, 1'b1, 5'd0, 1'b0),
           s_dep(5'd4, 1'b1, 5'd0, 1'b0), s_dep(5'd4, 1'b1, 5'd0, 1'b0),
           s_ld(5'd4), s_ld(5'd6), s_dep(5'd4, 1'b1, 5'd6, 1'b1),
           s_dep(5'd4, 1'b1, 5'd6, 1'b1), s_dep(5'd4, 1'b1, 5'd6, 1'b1),
           s_ld(5'd4), sl, sl, sl, s_dep(5'd8, 1'b1, 5'd0, 1'b0),
           s_dep(5'd8, 1'b1, 5'd0, 1'b0), s_dep(5'd8, 1'b1, 5'd0, 1'b0)};
    eq = '{RUN, RUN, STALL, STALL, RUN,
           RUN, RUN, STALL, STALL, RUN,
           RUN, STALL, STALL, RUN, STALL, STALL, RUN};
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk_i);
      got = obs(2); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk_i); #1;
    end
    drain();
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    apply(s_ld(5'd9));
    @(posedge clk_i); #1;
    apply(s_dep(5'd9, 1'b1, 5'd0, 1'b0));
    @(negedge clk_i);
    got = obs(2);
    n_cmp++;
    if (got !== STALL) begin
      n_err++;
      $display("FAIL areset_pre got=%b want=%b", got, STALL);
    end
    #1 rst_n_i = 1'b0;
    #1;
    got = obs(2);
    n_cmp++;
    if (got !== RUN) begin
      n_err++;
      $display("FAIL areset_now got=%b want=%b", got, RUN);
    end
`ifdef LOAD_USE_PERF_EN
    n_cmp++;
    if (scnt2 !== 32'd0) begin
      n_err++;
      $display("FAIL areset_perf got=%0d want=0", scnt2);
    end
`endif
    @(posedge clk_i); #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    got = obs(2);
    n_cmp++;
    if (got !== RUN) begin
      n_err++;
      $display("FAIL areset_post got=%b want=%b", got, RUN);
    end
    @(posedge clk_i); #1;
    drain();
  endtask

`ifdef LOAD_USE_PERF_EN
  task automatic test_perf();
    perf_clr_i = 1'b1;
    @(posedge clk_i); #1;
    perf_clr_i = 1'b0;
    n_cmp++;
    if (scnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL perf_clr got=%0d want=0", scnt1);
    end
    apply(s_ld(5'd5));
    @(posedge clk_i); #1;
    apply(s_dep(5'd5, 1'b1, 5'd0, 1'b0));
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (scnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL perf_count got=%0d want=1", scnt1);
    end
    // Clear wins over a simultaneous bubble.
    apply(s_ld(5'd5));
    @(posedge clk_i); #1;
    apply(s_dep(5'd5, 1'b1, 5'd0, 1'b0));
    perf_clr_i = 1'b1;
    @(posedge clk_i); #1;
    perf_clr_i = 1'b0;
    n_cmp++;
    if (scnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL perf_clr_prio got=%0d want=0", scnt1);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_classic();
    test_lat3();
    test_reg_zero();
    test_freeze();
    test_back_to_back();
    test_async_reset();
`ifdef LOAD_USE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use hazard detector in the ID stage.
- Keeps a per-register countdown scoreboard of in-flight loads. Supports configurable load-to-use latency and pipeline-wide memory freezes.
- Drives stall/bubble controls to PC, IF/ID and ID/EX.
- LOAD_LAT=1 reproduces the classic one-bubble load-use stall.

Parameters:
- NUM_REGS, 32, number of architectural registers (register 0 hardwired zero).
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- LOAD_LAT, 1, cycles after a load leaves ID during which its destination is not forwardable (1..7).
- CNT_W, $clog2(LOAD_LAT+1), derived width of each countdown counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID stage holds a real (non-flushed) instruction.
- id_rs_addr_i  in  ADDR_W  ID source register 1.
- id_rt_addr_i  in  ADDR_W  ID source register 2.
- id_uses_rs_i  in  1  instruction reads rs.
- id_uses_rt_i  in  1  instruction reads rt.
- id_mem_read_i  in  1  ID instruction is a load.
- id_rd_addr_i  in  ADDR_W  load destination register.
- freeze_i  in  1  pipeline-wide freeze (data memory busy); all state holds.
- stall_o  out  1  load-use hazard detected in ID.
- pc_write_o  out  1  PC write enable (~stall_o & ~freeze_i).
- ifid_write_o  out  1  IF/ID write enable (~stall_o & ~freeze_i).
- idex_bubble_o  out  1  insert NOP into ID/EX (stall_o & ~freeze_i).

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset: all counters cleared to 0. Outputs follow combinationally: stall_o=0, pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, perf counter 0. Reset mid-operation discards all pending loads.
- Scoreboard: cnt[r], CNT_W bits, r=1..NUM_REGS-1. cnt[0] is constant 0.
- Hazard (combinational, zero latency): stall_o = id_valid_i & ((id_uses_rs_i & rs!=0 & cnt[rs]!=0) | (id_uses_rt_i & rt!=0 & cnt[rt]!=0)).
- Issue condition: issue = id_valid_i & ~stall_o & ~freeze_i.
- Per-cycle update when freeze_i=0, for every r:
  - If issue & id_mem_read_i & id_rd_addr_i==r & r!=0: cnt[r] <= LOAD_LAT. Allocation wins over decrement and reloads an already-pending register.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- freeze_i=1: every counter holds. stall_o is still evaluated, but the bubble is suppressed and no allocation occurs.
- Stalled load: does not allocate; it re-evaluates next cycle.
- Addresses >= NUM_REGS: never allocate, never hazard.
- Latency: a dependent instruction arriving in ID the cycle after its producer load issued stalls for exactly LOAD_LAT cycles (absent freeze).
- No internal FSM beyond counters. Maximum simultaneous pending loads = min(LOAD_LAT, NUM_REGS-1).

Optional Feature:
- Macro: LOAD_USE_PERF_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits.
  - Increments on each cycle with idex_bubble_o=1; saturates at 32'hFFFF_FFFF.
  - Resets to 0.
  - Adds input perf_clr_i, synchronous clear, which has priority over increment.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W = 5, NUM_ARCH_REGS = 32, REG_ZERO = 0.
  - Default LOAD_LAT constant.
  - typedef reg_addr_t.
- One sub-module, lus_counter: a single CNT_W down-counter with load/freeze, instantiated via generate per register.

Test Plan:
- Classic load-use, LOAD_LAT=1: issue load r5, next cycle ID reads rs=5 -> stall_o=1 and idex_bubble_o=1 for exactly 1 cycle, pc_write_o=0 that cycle; following cycle stall_o=0.
- LOAD_LAT=3: load r7, then dependent rt=7 -> stall_o high exactly 3 cycles. Same with id_uses_rt_i=0 -> no stall.
- Register zero: load to r0, then dependent rs=0 -> stall_o never asserts, and cnt[0] stays 0.
- Freeze: LOAD_LAT=2, load r3, dependent in ID, freeze_i=1 for 4 cycles mid-stall:
  - During freeze: idex_bubble_o=0, pc_write_o=0.
  - After release: exactly the remaining stall cycles occur (total bubbles=2).
- Back-to-back loads, LOAD_LAT=2: loads to r4 then r4 again, then dependent on r4 -> counter reloaded, stall lasts 2 cycles after the second load. Loads to r4 and r6 both tracked independently.
- Async reset: assert rst_n_i mid-stall (cnt[9]=2) -> stall_o=0 immediately without clock edge; after release, dependent on r9 is not stalled. With LOUD_USE... LOAD_USE_PERF_EN defined, stall_cnt_o=0.
